// File: rtl/layer_output_packer.sv
// Collects serial final-layer neuron words into one packed frame and pulses o_data_valid once per frame.
// Optional PACK_SOF_CHECK_EN adds i_sof framing and a sticky o_err flag.
module layer_output_packer #(
   parameter int numInput   = 10,
   parameter int inputWidth = 16
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [inputWidth-1:0]            i_data,
   input  logic                             i_valid,
   input  logic                             i_flush,
`ifdef PACK_SOF_CHECK_EN
   input  logic                             i_sof,
   output logic                             o_err,
`endif
   output logic [numInput*inputWidth-1:0]   o_data,
   output logic                             o_data_valid,
   output logic [$clog2(numInput+1)-1:0]    o_count
);

   localparam int CW = $clog2(numInput + 1);
   localparam logic [CW-1:0] LAST = CW'(numInput - 1);

   // Handshake: i_valid marks i_data as a word this cycle and is always taken
   // (no ready); o_data_valid is a one-cycle pulse the consumer must catch.

   logic [numInput*inputWidth-1:0] buf_q;
   logic [numInput*inputWidth-1:0] merged;
   logic [CW-1:0]                  count_q;
   logic [CW-1:0]                  slot;
   logic                           accept;
   logic                           complete;
   logic                           err_set;

   always_comb begin
      slot     = count_q;
      accept   = i_valid & ~i_flush;
      err_set  = 1'b0;
`ifdef PACK_SOF_CHECK_EN
      // A start-of-frame always restarts collection at slot 0.
      if (i_sof) slot = '0;
      if (i_valid && i_sof && count_q != '0) err_set = 1'b1;
      if (i_valid && !i_sof && count_q == '0) begin
         accept  = 1'b0;
         err_set = 1'b1;
      end
`endif
      complete = accept && (slot == LAST);
   end

   always_comb begin
      merged = buf_q;
      for (int k = 0; k < numInput; k++) begin
         if (slot == CW'(k)) merged[k*inputWidth +: inputWidth] = i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         buf_q        <= '0;
         count_q      <= '0;
         o_data       <= '0;
         o_data_valid <= 1'b0;
      end else begin
         o_data_valid <= complete;
         if (i_flush || complete) count_q <= '0;
         else if (accept)         count_q <= slot + CW'(1);
         if (accept)   buf_q  <= merged;
         if (complete) o_data <= merged;
      end
   end

`ifdef PACK_SOF_CHECK_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     o_err <= 1'b0;
      else if (i_flush) o_err <= 1'b0;
      else if (err_set) o_err <= 1'b1;
   end
`endif

   assign o_count = count_q;

endmodule

// File: tb/tb_layer_output_packer.sv
// Directed bench for layer_output_packer (numInput=10, inputWidth=16).
// Framing-check steps are built only when PACK_SOF_CHECK_EN is defined.
module tb_layer_output_packer;

   localparam int N  = 10;
   localparam int W  = 16;
   localparam int CW = 4;

   localparam logic [N*W-1:0] FR_1 = 160'h000A_0009_0008_0007_0006_0005_0004_0003_0002_0001;
   localparam logic [N*W-1:0] FR_A = 160'h1009_1008_1007_1006_1005_1004_1003_1002_1001_1000;
   localparam logic [N*W-1:0] FR_B = 160'h2009_2008_2007_2006_2005_2004_2003_2002_2001_2000;
   localparam logic [N*W-1:0] FR_F = 160'h00F9_00F8_00F7_00F6_00F5_00F4_00F3_00F2_00F1_00F0;
   localparam logic [N*W-1:0] FR_S = 160'h0209_0208_0207_0206_0205_0204_0203_0202_0201_0200;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [W-1:0]   data  = '0;
   logic           valid = 1'b0;
   logic           flush = 1'b0;
   logic           sof   = 1'b0;
   logic [N*W-1:0] o_data;
   logic           o_data_valid;
   logic [CW-1:0]  o_count;
`ifdef PACK_SOF_CHECK_EN
   logic           o_err;
`endif

   int total     = 0;
   int bad       = 0;
   int pulse_cnt = 0;
   int pc0;

   layer_output_packer #(.numInput(N), .inputWidth(W)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_data       (data),
      .i_valid      (valid),
      .i_flush      (flush),
`ifdef PACK_SOF_CHECK_EN
      .i_sof        (sof),
      .o_err        (o_err),
`endif
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .o_count      (o_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (o_data_valid) pulse_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at a negedge; outputs are sampled at the following negedge.
   task automatic cycle(input logic v, input logic [W-1:0] d, input logic f, input logic s);
      valid = v; data = d; flush = f; sof = s;
      @(negedge clk);
      valid = 1'b0; flush = 1'b0; sof = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] base, input logic [N*W-1:0] hold, input string tag);
      for (int k = 0; k < N; k++) begin
         cycle(1'b1, base + W'(k), 1'b0, k == 0);
         if (k < N - 1) begin
            check({tag, "_count"}, o_count, k + 1);
            check({tag, "_nopulse"}, o_data_valid, 0);
            check({tag, "_hold"}, o_data, hold);
         end
      end
      check({tag, "_pulse"}, o_data_valid, 1);
      check({tag, "_count0"}, o_count, 0);
   endtask

   initial begin
      // reset state
      #1;
      check("rst_data", o_data, 0);
      check("rst_valid", o_data_valid, 0);
      check("rst_count", o_count, 0);
`ifdef PACK_SOF_CHECK_EN
      check("rst_err", o_err, 0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0);

      // 1: single frame
      send_frame(16'h0001, '0, "t1");
      check("t1_data", o_data, FR_1);
      cycle(1'b0, '0, 1'b0, 1'b0);
      check("t1_pulse_end", o_data_valid, 0);
      check("t1_held", o_data, FR_1);

      // 2: back-to-back frames
      send_frame(16'h1000, FR_1, "t2a");
      check("t2a_data", o_data, FR_A);
      send_frame(16'h2000, FR_A, "t2b");
      check("t2b_data", o_data, FR_B);

      // 3: gaps between words
      cycle(1'b0, '0, 1'b0, 1'b0);
      pc0 = pulse_cnt;
      for (int k = 0; k < N; k++) begin
         for (int g = $urandom_range(0, 5); g > 0; g--) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            check("t3_idle_count", o_count, k);
            check("t3_idle_nopulse", o_data_valid, 0);
         end
         cycle(1'b1, W'(k + 1), 1'b0, k == 0);
         if (k < N - 1) check("t3_hold", o_data, FR_B);
      end
      check("t3_pulse", o_data_valid, 1);
      check("t3_data", o_data, FR_1);
      cycle(1'b0, '0, 1'b0, 1'b0);
      check("t3_one_pulse", pulse_cnt - pc0, 1);

      // 4: flush mid-frame, then flush together with the final word
      for (int k = 0; k < 4; k++) cycle(1'b1, 16'h0050 + W'(k), 1'b0, k == 0);
      check("t4_count4", o_count, 4);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("t4_flush_count", o_count, 0);
      check("t4_flush_nopulse", o_data_valid, 0);
      send_frame(16'h00F0, FR_1, "t4");
      check("t4_data", o_data, FR_F);
      for (int k = 0; k < N - 1; k++) cycle(1'b1, 16'h0030 + W'(k), 1'b0, k == 0);
      check("t4_count9", o_count, 9);
      cycle(1'b1, 16'h0039, 1'b1, 1'b0);
      check("t4_lastflush_nopulse", o_data_valid, 0);
      check("t4_lastflush_count", o_count, 0);
      check("t4_lastflush_data", o_data, FR_F);
      cycle(1'b0, '0, 1'b0, 1'b0);
      check("t4_still_nopulse", o_data_valid, 0);

      // 5: async reset between clock edges mid-frame
      for (int k = 0; k < 6; k++) cycle(1'b1, 16'h0070 + W'(k), 1'b0, k == 0);
      check("t5_count6", o_count, 6);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_data", o_data, 0);
      check("t5_rst_valid", o_data_valid, 0);
      check("t5_rst_count", o_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(16'h0001, '0, "t5");
      check("t5_data", o_data, FR_1);
      cycle(1'b0, '0, 1'b0, 1'b0);

`ifdef PACK_SOF_CHECK_EN
      // 6: framing errors
      check("t6_err_clear", o_err, 0);
      for (int k = 0; k < 5; k++) cycle(1'b1, 16'h0100 + W'(k), 1'b0, k == 0);
      cycle(1'b1, 16'h0200, 1'b0, 1'b1);
      check("t6_sof_err", o_err, 1);
      check("t6_sof_count", o_count, 1);
      for (int k = 1; k < N; k++) begin
         cycle(1'b1, 16'h0200 + W'(k), 1'b0, 1'b0);
         if (k < N - 1) check("t6_count", o_count, k + 1);
      end
      check("t6_pulse", o_data_valid, 1);
      check("t6_data", o_data, FR_S);
      cycle(1'b1, 16'h0300, 1'b0, 1'b0);
      check("t6_drop_count", o_count, 0);
      check("t6_drop_nopulse", o_data_valid, 0);
      check("t6_err_sticky", o_err, 1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("t6_flush_err", o_err, 0);
      check("t6_data_kept", o_data, FR_S);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
